pwm_capture: RTL and testbench

Measures the period and high time of an incoming PWM waveform in `clk` cycles, the receive-side counterpart of the backlight/LCD PWM generator. Used to read back fan tachometer/PWM feedback or to loop-check the generator's output. It synchronises the asynchronous input and publishes one `period`/`duty` pair per completed cycle with a one-cycle valid strobe. It also flags a stuck-high or stuck-low input after a programmable timeout.

---
 rtl/pwm_capture.sv | 123 ++++++++++++
 tb/tb_pwm_capture.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// PWM period / high-time capture with stuck-input detection.
// Ports: clk, rst, pwm_in -> period, duty, meas_valid, stuck_high, stuck_low.
module pwm_capture #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [15:0] TIMEOUT     = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pwm_in,
  output logic [15:0] period,
  output logic [15:0] duty,
  output logic        meas_valid,
  output logic        stuck_high,
  output logic        stuck_low
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    MEASURE
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [15:0]            cnt_q, cnt_d;
  logic [15:0]            high_q, high_d;
  logic [15:0]            period_q, period_d;
  logic [15:0]            duty_q, duty_d;
  logic                   valid_q, valid_d;
  logic                   sh_q, sh_d;
  logic                   sl_q, sl_d;

  logic s, rise, fall, timeout;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~prev_q;
  assign fall = ~s & prev_q;

  // An edge in the timeout cycle wins: the period is still valid.
  assign timeout = (cnt_q == TIMEOUT) & ~rise & ~fall;

  always_comb begin
    cnt_d = cnt_q;
    if (rise)
      cnt_d = 16'd1;
    else if (cnt_q != 16'hFFFF)
      cnt_d = cnt_q + 16'd1;
  end

  assign high_d = fall ? cnt_q : high_q;

  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    duty_d   = duty_q;
    valid_d  = 1'b0;
    sh_d     = sh_q;
    sl_d     = sl_q;
    if (rise | fall) begin
      sh_d = 1'b0;
      sl_d = 1'b0;
    end
    if (timeout) begin
      sh_d     = s;
      sl_d     = ~s;
      period_d = '0;
      duty_d   = '0;
      state_d  = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rise) state_d = ARMED;
        end
        ARMED: begin
          if (fall) state_d = MEASURE;
        end
        MEASURE: begin
          if (rise) begin
            period_d = cnt_q;
            duty_d   = high_q;
            valid_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      prev_q   <= 1'b0;
      cnt_q    <= '0;
      high_q   <= '0;
      state_q  <= IDLE;
      period_q <= '0;
      duty_q   <= '0;
      valid_q  <= 1'b0;
      sh_q     <= 1'b0;
      sl_q     <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      prev_q   <= s;
      cnt_q    <= cnt_d;
      high_q   <= high_d;
      state_q  <= state_d;
      period_q <= period_d;
      duty_q   <= duty_d;
      valid_q  <= valid_d;
      sh_q     <= sh_d;
      sl_q     <= sl_d;
    end
  end

  assign period     = period_q;
  assign duty       = duty_q;
  assign meas_valid = valid_q;
  assign stuck_high = sh_q;
  assign stuck_low  = sl_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture with a strobe scoreboard.
// Expected period/duty pairs are queued as waveforms are driven.
module tb_pwm_capture;

  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pwm_in = 1'b0;
  logic [15:0] period;
  logic [15:0] duty;
  logic        meas_valid;
  logic        stuck_high;
  logic        stuck_low;

  int checks  = 0;
  int errors  = 0;
  int strobes = 0;

  logic [31:0] exp_q[$];
  bit          meas = 1'b0;
  int          ph = 0;
  int          pl = 0;

  always #5 clk = ~clk;

  pwm_capture #(
    .SYNC_STAGES(2),
    .TIMEOUT(16'(TO))
  ) dut (
    .clk(clk),
    .rst(rst),
    .pwm_in(pwm_in),
    .period(period),
    .duty(duty),
    .meas_valid(meas_valid),
    .stuck_high(stuck_high),
    .stuck_low(stuck_low)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (meas_valid) begin
      logic [31:0] e;
      strobes++;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_strobe observed period=%0d duty=%0d expected none",
               period, duty);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("period", 32'(period), 32'(e[31:16]));
        chk("duty", 32'(duty), 32'(e[15:0]));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One high/low cycle. A rise that closes a full prior cycle strobes.
  task automatic pulse(input int h, input int l);
    if (meas) exp_q.push_back({16'(ph + pl), 16'(ph)});
    pwm_in = 1'b1;
    idle(h);
    pwm_in = 1'b0;
    idle(l);
    meas = !((TO < h + l) && (TO != h));
    ph = h;
    pl = l;
  endtask

  task automatic pulses(input int h, input int l, input int n);
    for (int i = 0; i < n; i++) pulse(h, l);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    idle(n);
    rst = 1'b0;
    meas = 1'b0;
    strobes = 0;
  endtask

  task automatic seg_end(input string tag, input int n);
    idle(4);
    chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_strobes"}, 32'(strobes), 32'(n));
  endtask

  initial begin
    idle(3);
    chk("rst_period", 32'(period), 32'd0);
    chk("rst_duty", 32'(duty), 32'd0);
    chk("rst_valid", 32'(meas_valid), 32'd0);
    chk("rst_sh", 32'(stuck_high), 32'd0);
    chk("rst_sl", 32'(stuck_low), 32'd0);
    rst = 1'b0;
    strobes = 0;

    pulses(10, 30, 5);
    chk("s1_sh", 32'(stuck_high), 32'd0);
    chk("s1_sl", 32'(stuck_low), 32'd0);
    seg_end("s1", 4);

    do_reset(2);
    pulses(1, 1, 20);
    seg_end("s2", 19);

    do_reset(2);
    pulses(20, 20, 4);
    if (meas) exp_q.push_back({16'(ph + pl), 16'(ph)});
    pwm_in = 1'b1;
    idle(110);
    chk("s3_sh_set", 32'(stuck_high), 32'd1);
    chk("s3_sl", 32'(stuck_low), 32'd0);
    chk("s3_period0", 32'(period), 32'd0);
    chk("s3_duty0", 32'(duty), 32'd0);
    idle(40);
    meas = 1'b0;
    pwm_in = 1'b0;
    idle(20);
    chk("s3_sh_clr", 32'(stuck_high), 32'd0);
    pulses(20, 20, 3);
    seg_end("s3", 6);

    do_reset(2);
    idle(110);
    chk("s4_sl_set", 32'(stuck_low), 32'd1);
    chk("s4_sh", 32'(stuck_high), 32'd0);
    chk("s4_period0", 32'(period), 32'd0);
    pulses(25, 25, 3);
    chk("s4_sl_clr", 32'(stuck_low), 32'd0);
    seg_end("s4", 2);

    do_reset(2);
    pulses(60, 40, 3);
    if (meas) exp_q.push_back({16'(ph + pl), 16'(ph)});
    pwm_in = 1'b1;
    idle(5);
    meas = 1'b0;
    chk("s5_sh", 32'(stuck_high), 32'd0);
    chk("s5_sl", 32'(stuck_low), 32'd0);
    seg_end("s5", 3);
    pwm_in = 1'b0;
    idle(5);

    do_reset(2);
    pulses(10, 30, 2);
    if (meas) exp_q.push_back({16'(ph + pl), 16'(ph)});
    pwm_in = 1'b1;
    idle(10);
    pwm_in = 1'b0;
    idle(15);
    chk("s6_pre_period", 32'(period), 32'd40);
    rst = 1'b1;
    idle(1);
    chk("s6_rst_period", 32'(period), 32'd0);
    chk("s6_rst_duty", 32'(duty), 32'd0);
    chk("s6_rst_valid", 32'(meas_valid), 32'd0);
    rst = 1'b0;
    meas = 1'b0;
    idle(15);
    pulses(10, 30, 3);
    seg_end("s6", 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
